ram_march_bist: RTL
===================

Name: ram_march_bist

Overview:
- March C- built-in self-test engine that sits directly upstream of the 512x16 RAM (ram512) and owns its addr/data_in/we ports.
- Sweeps every word with solid and inverted backgrounds, compares read data against expected values, and reports pass/fail with first-failure capture.
- Used at power-up and on demand from the system controller; in functional mode the RAM port mux selects the normal master.

Parameters:
- ADDR_W, 9, RAM address width; DEPTH = 2**ADDR_W.
- DATA_W, 16, RAM word width.
- BG, 16'h0000, data background; "0" means BG and "1" means ~BG.
- RD_LAT, 1, cycles from read address issue to valid mem_data_out; legal values 0..3.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to run the test; ignored unless idle.
- mem_addr  out  ADDR_W  RAM address.
- mem_data_in  out  DATA_W  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_data_out  in  DATA_W  RAM read data.
- busy  out  1  test in progress.
- done  out  1  one-cycle pulse at test end.
- fail  out  1  sticky mismatch flag; cleared on the next start.
- fail_addr  out  ADDR_W  address of the first mismatch.
- fail_data  out  DATA_W  data read at the first mismatch.
- fail_exp  out  DATA_W  expected data at the first mismatch.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; mem_addr=0, mem_data_in=0, mem_we=0, busy=0, done=0, fail=0, fail_addr=0, fail_data=0, fail_exp=0.
- States: IDLE, M0..M5, DONE.
- Element order:
  - M0: ascending, w0.
  - M1: ascending, r0,w1.
  - M2: ascending, r1,w0.
  - M3: descending, r0,w1.
  - M4: descending, r1,w0.
  - M5: descending, r0.
- Read op:
  - Issue cycle: mem_addr=A, mem_we=0.
  - Then RD_LAT wait cycles with mem_addr held.
  - mem_data_out is compared in the cycle RD_LAT after issue, so a read costs RD_LAT+1 cycles.
  - With RD_LAT=0 the compare happens in the issue cycle.
- Write op: one cycle with mem_addr=A, mem_data_in=value, mem_we=1.
- mem_we is high only in write cycles.
- mem_data_in holds its last value when mem_we=0.
- Address sequencing:
  - Ascending elements run 0..DEPTH-1; descending elements run DEPTH-1..0.
  - The address counter wraps internally with no extra cycle between elements.
  - All ops for one address complete before the address steps.
- Start:
  - In IDLE, start=1 clears fail and the capture registers, sets busy next cycle, and issues the first M0 write in that same cycle.
  - start while busy has no effect.
- Mismatch:
  - A mismatch sets fail.
  - fail_addr/fail_data/fail_exp load only if fail was 0, so they capture the first failure only.
- End of test:
  - After the final M5 compare, the engine enters DONE for one cycle: done=1, busy=0, mem_we=0.
  - It then returns to IDLE.
- Latency for DEPTH=512, RD_LAT=1:
  - Elements take M0 512 + M1..M4 4x1536 + M5 1024 = 7680 cycles.
  - done is asserted 7681 cycles after the start-sampling edge.
- Reset during a run: immediate abort, all outputs return to reset values, and a partial RAM content is acceptable.
- start coincident with the DONE cycle is ignored.

Optional Feature:
BIST_STOP_ON_FAIL_EN
- Defined: on the first mismatch compare, the engine skips all remaining ops and enters DONE in the next cycle (done pulse, busy drops, fail=1).
- Undefined: the engine always runs the full march; fail stays sticky and the capture holds the first failure.

Test Plan:
- Fault-free RAM model (sync read, RD_LAT=1) -> done 7681 cycles after start, fail=0, no mem_we during read cycles.
- Bit 3 of address 9'h005 stuck at 1 -> fail=1, fail_addr=9'h005, fail_exp=16'h0000, fail_data=16'h0008 (M1 r0), done still at cycle 7681 (macro undefined).
- Same fault with BIST_STOP_ON_FAIL_EN -> done pulse one cycle after the M1 compare at address 9'h005, and no further mem_we after that compare.
- Address order monitor -> M0 writes 0x000..0x1FF ascending with data 0x0000; M3 reads begin at 0x1FF and end at 0x000; M5 ends at 0x000.
- reset driven low at cycle 3000 -> outputs zero asynchronously, busy=0; after release, start runs a full pass to done with fail=0.
- start pulsed at cycle 100 of a run -> ignored, single done at 7681; a second start after done clears fail from the previous faulty run.

Source files
------------

// File: rtl/ram_march_bist.sv
// ============================================================================
// ram_march_bist : March C- self-test engine driving a single-port RAM.
// Optional BIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ram_march_bist #(
    parameter int                ADDR_W = 9,
    parameter int                DATA_W = 16,
    parameter logic [DATA_W-1:0] BG     = '0,
    parameter int                RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [DATA_W-1:0] fail_exp
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_M0   = 3'd1;
    localparam logic [2:0] S_M1   = 3'd2;
    localparam logic [2:0] S_M2   = 3'd3;
    localparam logic [2:0] S_M3   = 3'd4;
    localparam logic [2:0] S_M4   = 3'd5;
    localparam logic [2:0] S_M5   = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;

    localparam logic              c_OP_RD    = 1'b0;
    localparam logic              c_OP_WR    = 1'b1;
    localparam logic [1:0]        c_LAT      = 2'(RD_LAT);
    localparam logic [ADDR_W-1:0] c_ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);

`ifdef BIST_STOP_ON_FAIL_EN
    localparam logic c_STOP_ON_FAIL = 1'b1;
`else
    localparam logic c_STOP_ON_FAIL = 1'b0;
`endif

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              op_q, op_d;
    logic [1:0]        lat_q, lat_d;
    logic [DATA_W-1:0] wdata_q;
    logic              fail_q;
    logic [ADDR_W-1:0] fail_addr_q;
    logic [DATA_W-1:0] fail_data_q;
    logic [DATA_W-1:0] fail_exp_q;

    logic              w_has_wr;
    logic              w_desc;
    logic [DATA_W-1:0] w_rexp;
    logic [DATA_W-1:0] w_wval;
    logic              w_busy;
    logic              w_done;
    logic              w_we;
    logic              w_cmp;
    logic              w_mis;
    logic              w_last;
    logic              w_step;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            op_q        <= c_OP_RD;
            lat_q       <= '0;
            wdata_q     <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_exp_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            lat_q   <= lat_d;
            if (w_we) begin
                wdata_q <= w_wval;
            end
            if (state_q == S_IDLE && start) begin
                fail_q      <= 1'b0;
                fail_addr_q <= '0;
                fail_data_q <= '0;
                fail_exp_q  <= '0;
            end else if (w_mis) begin
                fail_q <= 1'b1;
                if (!fail_q) begin
                    fail_addr_q <= addr_q;
                    fail_data_q <= mem_data_out;
                    fail_exp_q  <= w_rexp;
                end
            end
        end
    end

    assign w_last = w_desc ? (addr_q == '0) : (addr_q == c_ADDR_MAX);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        op_d    = op_q;
        lat_d   = lat_q;
        w_step  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_M0;
                    addr_d  = '0;
                    op_d    = c_OP_WR;
                    lat_d   = '0;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                if (op_q == c_OP_RD) begin
                    if (lat_q != c_LAT) begin
                        lat_d = lat_q + 2'd1;
                    end else if (c_STOP_ON_FAIL && w_mis) begin
                        state_d = S_DONE;
                    end else if (w_has_wr) begin
                        op_d  = c_OP_WR;
                        lat_d = '0;
                    end else begin
                        w_step = 1'b1;
                    end
                end else begin
                    w_step = 1'b1;
                end
                // Element boundary: jump straight to the next element's first address.
                if (w_step) begin
                    lat_d = '0;
                    if (!w_last) begin
                        addr_d = w_desc ? addr_q - c_ADDR_ONE : addr_q + c_ADDR_ONE;
                    end else begin
                        state_d = (state_q == S_M5) ? S_DONE : state_q + 3'd1;
                        addr_d  = (state_d == S_M3 || state_d == S_M4 || state_d == S_M5)
                                  ? c_ADDR_MAX : '0;
                    end
                    op_d = (state_d == S_M0) ? c_OP_WR : c_OP_RD;
                end
            end
        endcase
    end

    always_comb begin
        w_has_wr = 1'b1;
        w_desc   = 1'b0;
        w_rexp   = BG;
        w_wval   = BG;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        case (state_q)
            S_M0: w_busy = 1'b1;
            S_M1: begin
                w_busy = 1'b1;
                w_wval = ~BG;
            end
            S_M2: begin
                w_busy = 1'b1;
                w_rexp = ~BG;
            end
            S_M3: begin
                w_busy = 1'b1;
                w_desc = 1'b1;
                w_wval = ~BG;
            end
            S_M4: begin
                w_busy = 1'b1;
                w_desc = 1'b1;
                w_rexp = ~BG;
            end
            S_M5: begin
                w_busy   = 1'b1;
                w_desc   = 1'b1;
                w_has_wr = 1'b0;
            end
            S_DONE:  w_done = 1'b1;
            default: w_busy = 1'b0;
        endcase
        w_we  = w_busy && (op_q == c_OP_WR);
        w_cmp = w_busy && (op_q == c_OP_RD) && (lat_q == c_LAT);
        w_mis = w_cmp && (mem_data_out != w_rexp);
    end

    assign mem_addr    = addr_q;
    assign mem_we      = w_we;
    assign mem_data_in = w_we ? w_wval : wdata_q;
    assign busy        = w_busy;
    assign done        = w_done;
    assign fail        = fail_q;
    assign fail_addr   = fail_addr_q;
    assign fail_data   = fail_data_q;
    assign fail_exp    = fail_exp_q;

endmodule

`default_nettype wire
